// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Multi-cycle responder for MEM-stage data-memory requests. Each 32-bit read
// or write is split into two half-word accesses to an external 16-bit
// asynchronous SRAM: the low half first, then the high half. Each access is
// held for WAIT_CYCLES clocks. `ready` stays low for the whole transfer so the
// top level can freeze the pipeline with ~ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   wr_en        write request (level); wins over rd_en when both are set
//   rd_en        read request (level)
//   address      byte address; BASE_ADDR maps to SRAM half-word 0
//   write_data   store data
//   read_data    load data, registered, held until the next read
//   ready        high when idle with no request, or in the DONE cycle
//   sram_addr    SRAM half-word address
//   sram_dq_out  data driven towards the SRAM
//   sram_dq_in   data returned by the SRAM
//   sram_dq_oe   enable for the top-level DQ tristate driver
//   sram_we_n    SRAM write strobe, active low
// -----------------------------------------------------------------------------
module sram_controller #(
   parameter int ADDRESS_LEN = 32,
   parameter int SRAM_ADDR_W = 18,
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [ADDRESS_LEN-1:0] address,
   input  logic [ADDRESS_LEN-1:0] write_data,
   output logic [ADDRESS_LEN-1:0] read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   // A one-bit counter is kept even when WAIT_CYCLES is 1 so the vector is
   // never zero width; it simply stays at 0 in that case.
   localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic                   is_write;
   logic [SRAM_ADDR_W-2:0] word_idx;
   logic [15:0]            data_hi;

   // Offset from the SRAM window base; wraps modulo 2^ADDRESS_LEN for
   // addresses below the base.
   logic [ADDRESS_LEN-1:0] offset_next;
   assign offset_next = address - ADDRESS_LEN'(BASE_ADDR);

   // Byte-within-word bits and bits beyond the SRAM size are deliberately
   // dropped: accesses are word aligned and wrap inside the SRAM.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{offset_next[ADDRESS_LEN-1:SRAM_ADDR_W+1], offset_next[1:0]};

   wire req       = wr_en | rd_en;
   wire phase_end = (cnt == CNT_LAST);

   // NOTE: ready is a pure function of state and request, so the pipeline sees
   // a new request stall in the same cycle it is raised; a continuous assign
   // cannot infer a latch.
   assign ready = ((state == IDLE) && !req) || (state == DONE);

   // The SRAM pins are registered: every assignment below sets the pin values
   // for the state being entered, so they are valid from the first cycle of
   // each phase.
   // NOTE: all state in this block uses non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         is_write    <= 1'b0;
         word_idx    <= '0;
         data_hi     <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state       <= LOW;
                  cnt         <= '0;
                  is_write    <= wr_en;
                  word_idx    <= offset_next[SRAM_ADDR_W:2];
                  data_hi     <= write_data[31:16];
                  sram_addr   <= {offset_next[SRAM_ADDR_W:2], 1'b0};
                  sram_dq_out <= wr_en ? write_data[15:0] : 16'h0000;
                  sram_dq_oe  <= wr_en;
                  sram_we_n   <= ~wr_en;
               end
            end

            LOW: begin
               if (phase_end) begin
                  state     <= HIGH;
                  cnt       <= '0;
                  sram_addr <= {word_idx, 1'b1};
                  if (is_write) begin
                     sram_dq_out <= data_hi;
                  end else begin
                     read_data[15:0] <= sram_dq_in;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            HIGH: begin
               if (phase_end) begin
                  state       <= DONE;
                  cnt         <= '0;
                  sram_addr   <= '0;
                  sram_dq_out <= '0;
                  sram_dq_oe  <= 1'b0;
                  sram_we_n   <= 1'b1;
                  if (!is_write) begin
                     read_data[31:16] <= sram_dq_in;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Self-checking bench for sram_controller. One instance uses the default
// WAIT_CYCLES=2 and talks to a behavioural asynchronous SRAM; a second
// instance uses WAIT_CYCLES=1 to check short timing and the top of the SRAM.
// Expected values come from a word-level reference memory updated with the
// address/offset arithmetic of the block's description.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps
module tb_sram_controller;

   localparam int W      = 2;
   localparam int SRAM_N = 1 << 18;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        s_wr_en, s_rd_en;
   logic [31:0] s_address, s_write_data, s_read_data;
   logic        s_ready;
   logic [17:0] s_sram_addr;
   logic [15:0] s_sram_dq_out, s_sram_dq_in;
   logic        s_sram_dq_oe, s_sram_we_n;

   always #5 clk = ~clk;

   sram_controller #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   sram_controller #(.WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .rst(rst), .wr_en(s_wr_en), .rd_en(s_rd_en),
      .address(s_address), .write_data(s_write_data), .read_data(s_read_data),
      .ready(s_ready), .sram_addr(s_sram_addr), .sram_dq_out(s_sram_dq_out),
      .sram_dq_in(s_sram_dq_in), .sram_dq_oe(s_sram_dq_oe), .sram_we_n(s_sram_we_n)
   );

   // Short-timing instance reads a fixed pattern derived from the address.
   assign s_sram_dq_in = ~s_sram_addr[15:0];

   // Behavioural SRAM: combinational read; a half-word is committed only after
   // the write strobe has been held at one address for a full write cycle of
   // W clocks, so a write cut short by reset leaves the cell untouched.
   logic [15:0] mem     [0:SRAM_N-1];
   logic [15:0] exp_mem [0:SRAM_N-1];
   int          wr_run;
   logic [17:0] wr_addr;

   assign sram_dq_in = mem[sram_addr];

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) begin
         wr_run  <= (wr_run != 0 && sram_addr == wr_addr) ? wr_run + 1 : 1;
         wr_addr <= sram_addr;
         if (((wr_run != 0 && sram_addr == wr_addr) ? wr_run + 1 : 1) == W)
            mem[sram_addr] <= sram_dq_out;
      end else begin
         wr_run <= 0;
      end
   end

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] prev_rd;

   // Half-word index of the low half for a byte address.
   function automatic logic [17:0] lo_index(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'd1024;
      return {off[18:2], 1'b0};
   endfunction

   // Runs one transfer starting in the cycle after the call and stops in the
   // DONE cycle (ready high). Observations only; callers compare.
   task automatic xfer(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic scramble,
                       output int low, output int wes, output int oes,
                       output int agood, output logic [31:0] rd);
      logic [17:0] lo;
      logic [17:0] want_addr;
      lo = lo_index(a);
      @(negedge clk);
      wr_en = w; rd_en = r; address = a; write_data = d;
      #1;
      low = 0; wes = 0; oes = 0; agood = 0; rd = '0;
      for (int k = 0; k < 64; k++) begin
         if (ready === 1'b1) begin
            rd = read_data;
            break;
         end
         low++;
         if (sram_we_n === 1'b0) wes++;
         if (sram_dq_oe === 1'b1) oes++;
         want_addr = (k == 0) ? 18'd0 : (k <= W) ? lo : (lo | 18'd1);
         if (sram_addr === want_addr) agood++;
         @(negedge clk);
         if (scramble) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            address = $urandom;
            write_data = $urandom;
         end
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      s_wr_en = 1'b0; s_rd_en = 1'b0; s_address = '0; s_write_data = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b want 1", sram_we_n); end
      n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", sram_dq_oe); end
      n_cmp++; if (sram_addr !== 18'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
      n_cmp++; if (sram_dq_out !== 16'd0) begin n_err++; $display("FAIL rst_dq_out: got %h want 0", sram_dq_out); end
      n_cmp++; if (read_data !== 32'd0) begin n_err++; $display("FAIL rst_read_data: got %h want 0", read_data); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_idle: got %b want 1", ready); end
      n_cmp++; if (s_ready !== 1'b1 || s_sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst_w1: got ready=%b we_n=%b want 1 1", s_ready, s_sram_we_n); end
      // A request during reset drops ready but must not start a transfer.
      wr_en = 1'b1; #1;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_req: got %b want 0", ready); end
      @(negedge clk);
      n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL rst_no_start: got %b want 1", sram_we_n); end
      wr_en = 1'b0; rst = 1'b0;
      prev_rd = 32'd0;
   endtask

   task automatic test_idle;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL idle_ready[%0d]: got %b want 1", i, ready); end
         n_cmp++; if (sram_we_n !== 1'b1) begin n_err++; $display("FAIL idle_we_n[%0d]: got %b want 1", i, sram_we_n); end
         n_cmp++; if (sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL idle_oe[%0d]: got %b want 0", i, sram_dq_oe); end
      end
   endtask

   task automatic test_write_read;
      int low, wes, oes, agood;
      logic [31:0] rd;
      xfer(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, low, wes, oes, agood, rd);
      exp_mem[0] = 16'hBEEF; exp_mem[1] = 16'hDEAD;
      n_cmp++; if (low !== 2*W+1) begin n_err++; $display("FAIL wr1_ready_low: got %0d want %0d", low, 2*W+1); end
      n_cmp++; if (wes !== 2*W) begin n_err++; $display("FAIL wr1_we_cycles: got %0d want %0d", wes, 2*W); end
      n_cmp++; if (agood !== 2*W+1) begin n_err++; $display("FAIL wr1_addr_seq: got %0d good want %0d", agood, 2*W+1); end
      n_cmp++; if (mem[0] !== 16'hBEEF) begin n_err++; $display("FAIL wr1_hw0: got %h want BEEF", mem[0]); end
      n_cmp++; if (mem[1] !== 16'hDEAD) begin n_err++; $display("FAIL wr1_hw1: got %h want DEAD", mem[1]); end
      n_cmp++; if (rd !== prev_rd) begin n_err++; $display("FAIL wr1_rd_kept: got %h want %h", rd, prev_rd); end
      xfer(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, low, wes, oes, agood, rd);
      n_cmp++; if (low !== 2*W+1) begin n_err++; $display("FAIL rd1_ready_low: got %0d want %0d", low, 2*W+1); end
      n_cmp++; if (wes !== 0 || oes !== 0) begin n_err++; $display("FAIL rd1_no_drive: got we=%0d oe=%0d want 0 0", wes, oes); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd1_data: got %h want DEADBEEF", rd); end
      prev_rd = 32'hDEADBEEF;
   endtask

   task automatic test_unaligned;
      int low, wes, oes, agood;
      logic [31:0] rd;
      xfer(1'b1, 1'b0, 32'd1030, 32'h12345678, 1'b0, low, wes, oes, agood, rd);
      exp_mem[2] = 16'h5678; exp_mem[3] = 16'h1234;
      n_cmp++; if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin n_err++; $display("FAIL unal_hw23: got %h %h want 5678 1234", mem[2], mem[3]); end
      n_cmp++; if (agood !== 2*W+1) begin n_err++; $display("FAIL unal_addr_seq: got %0d good want %0d", agood, 2*W+1); end
      xfer(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, low, wes, oes, agood, rd);
      n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL unal_read: got %h want 12345678", rd); end
      prev_rd = 32'h12345678;
   endtask

   task automatic test_both;
      int low, wes, oes, agood;
      logic [31:0] rd;
      xfer(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 1'b0, low, wes, oes, agood, rd);
      exp_mem[0] = 16'hA5A5; exp_mem[1] = 16'hA5A5;
      n_cmp++; if (wes !== 2*W) begin n_err++; $display("FAIL both_we_cycles: got %0d want %0d", wes, 2*W); end
      n_cmp++; if (rd !== prev_rd) begin n_err++; $display("FAIL both_rd_kept: got %h want %h", rd, prev_rd); end
      n_cmp++; if (mem[0] !== 16'hA5A5 || mem[1] !== 16'hA5A5) begin n_err++; $display("FAIL both_mem: got %h %h want A5A5 A5A5", mem[0], mem[1]); end
   endtask

   task automatic test_reset_mid;
      int low, wes, oes, agood;
      logic [31:0] rd;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D;
      repeat (3) @(negedge clk);   // now in T3, first HIGH cycle
      wr_en = 1'b0;
      n_cmp++; if (sram_addr !== 18'd1 || sram_we_n !== 1'b0) begin n_err++; $display("FAIL rmid_in_high: got addr=%h we_n=%b want 1 0", sram_addr, sram_we_n); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_mem[0] = 16'hF00D;
      n_cmp++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_err++; $display("FAIL rmid_idle: got we_n=%b oe=%b want 1 0", sram_we_n, sram_dq_oe); end
      n_cmp++; if (ready !== 1'b1 || sram_addr !== 18'd0) begin n_err++; $display("FAIL rmid_ready: got ready=%b addr=%h want 1 0", ready, sram_addr); end
      n_cmp++; if (mem[0] !== 16'hF00D) begin n_err++; $display("FAIL rmid_hw0: got %h want F00D", mem[0]); end
      n_cmp++; if (mem[1] !== exp_mem[1]) begin n_err++; $display("FAIL rmid_hw1: got %h want %h", mem[1], exp_mem[1]); end
      n_cmp++; if (read_data !== 32'd0) begin n_err++; $display("FAIL rmid_rd_cleared: got %h want 0", read_data); end
      xfer(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, low, wes, oes, agood, rd);
      n_cmp++; if (low !== 2*W+1) begin n_err++; $display("FAIL rmid_read_low: got %0d want %0d", low, 2*W+1); end
      n_cmp++; if (rd !== {exp_mem[1], 16'hF00D}) begin n_err++; $display("FAIL rmid_read: got %h want %h", rd, {exp_mem[1], 16'hF00D}); end
      prev_rd = rd;
   endtask

   task automatic test_wait1;
      int          low;
      logic [17:0] a1, a2;
      logic        drive_ok;
      @(negedge clk);
      s_rd_en = 1'b1; s_address = 32'd1024 + 32'd4 * ((32'd1 << 17) - 32'd1);
      #1;
      low = 0; a1 = '0; a2 = '0; drive_ok = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (s_ready === 1'b1) break;
         low++;
         if (k == 1) a1 = s_sram_addr;
         if (k == 2) a2 = s_sram_addr;
         if (s_sram_we_n !== 1'b1 || s_sram_dq_oe !== 1'b0 || s_sram_dq_out !== 16'd0) drive_ok = 1'b0;
         @(negedge clk);
         s_rd_en = 1'b0;   // dropped mid-transfer; must still complete
      end
      n_cmp++; if (low !== 3) begin n_err++; $display("FAIL w1_ready_low: got %0d want 3", low); end
      n_cmp++; if (a1 !== 18'h3FFFE) begin n_err++; $display("FAIL w1_addr_lo: got %h want 3FFFE", a1); end
      n_cmp++; if (a2 !== 18'h3FFFF) begin n_err++; $display("FAIL w1_addr_hi: got %h want 3FFFF", a2); end
      n_cmp++; if (!drive_ok) begin n_err++; $display("FAIL w1_read_no_drive: got driving want idle pins"); end
      n_cmp++; if (s_read_data !== 32'h00000001) begin n_err++; $display("FAIL w1_read_data: got %h want 00000001", s_read_data); end
   endtask

   // Random back-to-back transfers with inputs scrambled mid-transfer.
   task automatic test_back_to_back;
      int          low, wes, oes, agood;
      logic [31:0] rd, a, d, want;
      logic        w, r, scr;
      logic [17:0] lo;
      for (int i = 0; i < 40; i++) begin
         {w, r} = 2'($urandom_range(1, 3));
         a   = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + 32'($urandom_range(0, 63));
         d   = $urandom;
         scr = 1'($urandom_range(0, 1));
         lo  = lo_index(a);
         xfer(w, r, a, d, scr, low, wes, oes, agood, rd);
         n_cmp++; if (low !== 2*W+1) begin n_err++; $display("FAIL b2b_ready_low[%0d]: got %0d want %0d", i, low, 2*W+1); end
         n_cmp++; if (agood !== 2*W+1) begin n_err++; $display("FAIL b2b_addr_seq[%0d]: got %0d good want %0d", i, agood, 2*W+1); end
         n_cmp++; if (wes !== (w ? 2*W : 0) || oes !== (w ? 2*W : 0)) begin n_err++; $display("FAIL b2b_strobes[%0d]: got we=%0d oe=%0d want %0d", i, wes, oes, w ? 2*W : 0); end
         if (w) begin
            exp_mem[lo] = d[15:0]; exp_mem[lo | 18'd1] = d[31:16];
            n_cmp++; if ({mem[lo | 18'd1], mem[lo]} !== d) begin n_err++; $display("FAIL b2b_mem[%0d]: got %h want %h", i, {mem[lo | 18'd1], mem[lo]}, d); end
            n_cmp++; if (rd !== prev_rd) begin n_err++; $display("FAIL b2b_rd_kept[%0d]: got %h want %h", i, rd, prev_rd); end
         end else begin
            want = {exp_mem[lo | 18'd1], exp_mem[lo]};
            n_cmp++; if (rd !== want) begin n_err++; $display("FAIL b2b_read[%0d]: got %h want %h", i, rd, want); end
            prev_rd = want;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < SRAM_N; i++) begin
         mem[i]     = 16'(i) ^ 16'h5A5A;
         exp_mem[i] = 16'(i) ^ 16'h5A5A;
      end
      wr_run = 0; wr_addr = '0;
      test_reset;
      test_idle;
      test_write_read;
      test_unaligned;
      test_both;
      test_reset_mid;
      test_wait1;
      test_back_to_back;
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
